multipit: RTL

// Multi-channel programmable interval timer, the parametrised successor to the single-channel PIT.

---
 rtl/multipit.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/multipit.sv
// multipit: multi-channel programmable interval timer.
// CHANNELS independent WIDTH-bit down-counters sharing one prescaler. Each
// channel is one-shot or repeating, can run from clk or from the prescaler
// tick, and raises a registered expiry pulse plus a sticky pending flag.
module multipit #(
  parameter int CHANNELS   = 4,
  parameter int WIDTH      = 16,
  parameter int PRESCALE_W = 8,
  localparam int CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cfg_we,
  input  logic [CH_W-1:0]       cfg_ch,
  input  logic [WIDTH-1:0]      cfg_reload,
  input  logic                  cfg_repeat,
  input  logic                  cfg_prescale,
  input  logic [PRESCALE_W-1:0] prescale_div,
  input  logic [CHANNELS-1:0]   irq_ack,
  output logic [CHANNELS-1:0]   irq_pulse,
  output logic [CHANNELS-1:0]   irq_pending,
  output logic                  irq,
  output logic [CHANNELS-1:0]   running,
  output logic [WIDTH-1:0]      status_count
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic                  tick_s;

  logic [WIDTH-1:0]      count_q  [CHANNELS];
  logic [WIDTH-1:0]      count_d  [CHANNELS];
  logic [WIDTH-1:0]      reload_q [CHANNELS];
  logic [WIDTH-1:0]      reload_d [CHANNELS];
  logic [CHANNELS-1:0]   repeat_q, repeat_d;
  logic [CHANNELS-1:0]   presc_q, presc_d;
  logic [CHANNELS-1:0]   running_q, running_d;
  logic [CHANNELS-1:0]   pulse_q, pulse_d;
  logic [CHANNELS-1:0]   pending_q, pending_d;

  logic [CHANNELS-1:0]   wr_hit_s;
  logic [CHANNELS-1:0]   adv_s;
  logic [CHANNELS-1:0]   fire_s;
  logic [WIDTH-1:0]      status_s;

  // Shared prescaler: >= compare so a divider lowered below pcnt wraps at once.
  always_comb begin
    tick_s = (pcnt_q >= prescale_div);
    if (tick_s) begin
      pcnt_d = '0;
    end else begin
      pcnt_d = pcnt_q + PRESCALE_W'(1);
    end
  end

  // Per-channel strobes: write select, advance enable and expiry detect.
  always_comb begin
    wr_hit_s = '0;
    adv_s    = '0;
    fire_s   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      wr_hit_s[i] = cfg_we & (cfg_ch == CH_W'(i));
      adv_s[i]    = running_q[i] & (presc_q[i] ? tick_s : 1'b1);
      fire_s[i]   = adv_s[i] & (count_q[i] == WIDTH'(1));
    end
  end

  // Channel next state; a config write overrides expiry and ack on its channel.
  always_comb begin
    repeat_d  = repeat_q;
    presc_d   = presc_q;
    running_d = running_q;
    pulse_d   = '0;
    pending_d = pending_q;
    for (int i = 0; i < CHANNELS; i++) begin
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      if (wr_hit_s[i]) begin
        reload_d[i]  = cfg_reload;
        count_d[i]   = cfg_reload;
        repeat_d[i]  = cfg_repeat;
        presc_d[i]   = cfg_prescale;
        running_d[i] = (cfg_reload != WIDTH'(0));
        pending_d[i] = 1'b0;
        pulse_d[i]   = 1'b0;
      end else begin
        pulse_d[i] = fire_s[i];
        if (fire_s[i]) begin
          if (repeat_q[i]) begin
            count_d[i] = reload_q[i];
          end else begin
            count_d[i]   = '0;
            running_d[i] = 1'b0;
          end
        end else if (adv_s[i] && (count_q[i] > WIDTH'(1))) begin
          count_d[i] = count_q[i] - WIDTH'(1);
        end else begin
          count_d[i] = count_q[i];
        end
        // Expiry wins over a same-edge ack so no event is lost.
        if (fire_s[i]) begin
          pending_d[i] = 1'b1;
        end else if (irq_ack[i]) begin
          pending_d[i] = 1'b0;
        end else begin
          pending_d[i] = pending_q[i];
        end
      end
    end
  end

  // Count readback mux; a select with no matching channel reads as zero.
  always_comb begin
    status_s = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      status_s = (cfg_ch == CH_W'(i)) ? count_q[i] : status_s;
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pcnt_q    <= '0;
      repeat_q  <= '0;
      presc_q   <= '0;
      running_q <= '0;
      pulse_q   <= '0;
      pending_q <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      pcnt_q    <= pcnt_d;
      repeat_q  <= repeat_d;
      presc_q   <= presc_d;
      running_q <= running_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      for (int i = 0; i < CHANNELS; i++) begin
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
      end
    end
  end

  assign irq_pulse    = pulse_q;
  assign irq_pending  = pending_q;
  assign irq          = |pending_q;
  assign running      = running_q;
  assign status_count = status_s;

endmodule
